// File: rtl/vpu_pkg.sv
// Shared types for the vector processing unit: opcodes, lane ALU controls,
// controller states and instruction field positions.
package vpu_pkg;

  typedef enum logic [3:0] {
    OP_ALU   = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_MOVI  = 4'd3,
    OP_JUMP  = 4'd4
  } opcode_e;

  // Unlisted controls pass operand a through unchanged.
  typedef enum logic [3:0] {
    ALU_FADD = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ALU_WAIT,
    S_MEM_REQ,
    S_MEM_RESP,
    S_HALTED,
    S_ERR
  } state_e;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int CTRL_MSB = 27;
  localparam int CTRL_LSB = 24;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 8;
  localparam int RS2_LSB  = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

endpackage

// File: rtl/alu_bf16.sv
// One SIMD lane: bf16 add (truncating, denormals flushed) plus integer ops.
// Purely combinational, no flow control.
module alu_bf16
  import vpu_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic [3:0]      ctrl,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] y
);

  logic [15:0] fa, fb, big, sml, mb, ms, diff, fsum;
  logic [7:0]  eb, es, d;
  logic [16:0] sum;
  logic [4:0]  lz;
  logic [8:0]  ex;
  logic [6:0]  man;

  always_comb begin
    fa = 16'(a);
    fb = 16'(b);
    if (fa[14:0] >= fb[14:0]) begin
      big = fa;
      sml = fb;
    end else begin
      big = fb;
      sml = fa;
    end
    eb   = big[14:7];
    es   = sml[14:7];
    d    = eb - es;
    // Eight guard bits below the mantissa keep aligned-off bits for the sum.
    mb   = (eb != 8'd0) ? {1'b1, big[6:0], 8'h00} : 16'h0000;
    ms   = (es != 8'd0) ? ({1'b1, sml[6:0], 8'h00} >> d) : 16'h0000;
    sum  = {1'b0, mb} + {1'b0, ms};
    diff = mb - ms;
    lz   = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) lz = 5'(15 - i);
    end
    ex   = 9'd0;
    man  = 7'd0;
    fsum = 16'h0000;
    if (eb == 8'd0) begin
      fsum = 16'h0000;
    end else if (big[15] == sml[15]) begin
      if (sum[16]) begin
        ex  = {1'b0, eb} + 9'd1;
        man = 7'(sum >> 9);
      end else begin
        ex  = {1'b0, eb};
        man = 7'(sum >> 8);
      end
      fsum = (ex >= 9'd255) ? {big[15], 8'hFF, 7'h00} : {big[15], ex[7:0], man};
    end else if (diff == 16'h0000 || {1'b0, eb} <= {4'b0000, lz}) begin
      fsum = 16'h0000;
    end else begin
      ex   = {1'b0, eb} - {4'b0000, lz};
      man  = 7'((diff << lz) >> 8);
      fsum = {big[15], ex[7:0], man};
    end

    case (ctrl)
      ALU_FADD: y = BITS'(fsum);
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/vpu_reg_file.sv
// Vector register file: two combinational read ports, one synchronous write.
// Contents are intentionally not reset.
module vpu_reg_file #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 512
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/vector_processing_unit.sv
// Single-issue SIMD controller: fetch, execute ALU/LOAD/STORE/MOVI/JUMP, halt.
// One instruction in flight; fetch and memory wait indefinitely on valid/ready.
module vector_processing_unit
  import vpu_pkg::*;
#(
  parameter int CORES       = 32,
  parameter int BITS        = 16,
  parameter int REG_ADDR_W  = 8,
  parameter int ALU_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           start_pc,
  output logic                  instr_req,
  output logic [15:0]           instr_addr,
  input  logic                  instr_valid,
  input  logic [31:0]           instr_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [15:0]           mem_addr,
  output logic [CORES*BITS-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [CORES*BITS-1:0] mem_rdata,
  output logic                  busy,
  output logic                  finished,
  output logic                  error
);

  localparam int W     = CORES * BITS;
  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]            op, alu_ctrl;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2, ra_addr;
  logic [15:0]           imm;
  logic                  rf_we;
  logic [W-1:0]          rf_wdata, ra_data, rb_data, alu_y;

  assign op       = instr_q[OP_MSB:OP_LSB];
  assign alu_ctrl = instr_q[CTRL_MSB:CTRL_LSB];
  assign rd       = instr_q[RD_LSB +: REG_ADDR_W];
  assign rs1      = instr_q[RS1_LSB +: REG_ADDR_W];
  assign rs2      = instr_q[RS2_LSB +: REG_ADDR_W];
  assign imm      = instr_q[IMM_MSB:IMM_LSB];
  // STORE reads its source through port a from the rd field.
  assign ra_addr  = (op == OP_STORE) ? rd : rs1;

  vpu_reg_file #(.ADDR_W(REG_ADDR_W), .DATA_W(W)) u_reg_file (
    .clock   (clock),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata),
    .raddr_a (ra_addr),
    .rdata_a (ra_data),
    .raddr_b (rs2),
    .rdata_b (rb_data)
  );

  for (genvar g = 0; g < CORES; g++) begin : g_lane
    alu_bf16 #(.BITS(BITS)) u_alu (
      .ctrl (alu_ctrl),
      .a    (ra_data[g*BITS +: BITS]),
      .b    (rb_data[g*BITS +: BITS]),
      .y    (alu_y[g*BITS +: BITS])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= 16'h0000;
      instr_q <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    rf_we      = 1'b0;
    rf_wdata   = alu_y;
    instr_req  = 1'b0;
    instr_addr = 16'h0000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE, S_HALTED, S_ERR: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_req  = 1'b1;
        instr_addr = pc_q;
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // HALT shares opcode 0 with ALU, so it must be recognised first.
        if (instr_q == HALT_INSTR) begin
          state_d = S_HALTED;
        end else begin
          case (op)
            OP_ALU: begin
              cnt_d   = CNT_W'(ALU_LATENCY - 1);
              state_d = S_ALU_WAIT;
            end
            OP_STORE, OP_LOAD: state_d = S_MEM_REQ;
            OP_MOVI: begin
              rf_we    = 1'b1;
              rf_wdata = {CORES{BITS'(imm)}};
              pc_d     = pc_q + 16'd1;
              state_d  = S_FETCH;
            end
            OP_JUMP: begin
              pc_d    = imm;
              state_d = S_FETCH;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_ALU_WAIT: begin
        if (cnt_q == '0) begin
          rf_we   = 1'b1;
          pc_d    = pc_q + 16'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MEM_REQ: begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_STORE);
        mem_addr  = imm;
        mem_wdata = (op == OP_STORE) ? ra_data : '0;
        if (mem_ready) begin
          if (op == OP_STORE) begin
            pc_d    = pc_q + 16'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_MEM_RESP;
          end
        end
      end
      S_MEM_RESP: begin
        if (mem_rvalid) begin
          rf_we    = 1'b1;
          rf_wdata = mem_rdata;
          pc_d     = pc_q + 16'd1;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_ALU_WAIT) ||
                    (state_q == S_MEM_REQ) || (state_q == S_MEM_RESP);
  assign finished = (state_q == S_HALTED);
  assign error    = (state_q == S_ERR);

endmodule
